// File: rtl/boot_loader_ctrl.sv
// Post-reset boot sequencer: copies BOOT_LEN words from ROM to RAM, then releases the CPU.
// Only samples the shared data bus; the ROM is tristated by the system once o_boot_done is high.
module boot_loader_ctrl #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned WORD_W      = 16,
  parameter int unsigned BOOT_LEN    = 3,
  parameter int unsigned ADDR_STEP   = 2,
  parameter int unsigned SETTLE_CYC  = 1,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_boot_req,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [WORD_W-1:0] i_bus_data,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [WORD_W-1:0] o_ram_wdata,
  output logic              o_ram_we,
  input  logic              i_ram_ack,
  output logic              o_boot_done,
  output logic              o_cpu_hold,
  output logic              o_boot_err
);

  localparam int unsigned CNT_MAX = (SETTLE_CYC > ACK_TIMEOUT) ? SETTLE_CYC : ACK_TIMEOUT;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned IDX_W   = (BOOT_LEN > 1) ? $clog2(BOOT_LEN) : 1;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(BOOT_LEN - 1);

  typedef enum logic [1:0] {StFetch, StWrite, StDone, StError} state_e;

  state_e              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]   r_ram_addr, w_ram_addr_nxt;
  logic [WORD_W-1:0]   r_ram_wdata, w_ram_wdata_nxt;
  logic                r_ram_we, w_ram_we_nxt;
  logic                r_done, w_done_nxt;
  logic                r_hold, w_hold_nxt;
  logic                r_err, w_err_nxt;
  logic [ADDR_W-1:0]   w_rom_addr;

  // ROM address is a pure function of the registered word index, so it never glitches.
  assign w_rom_addr = ADDR_W'(32'(r_idx) * ADDR_STEP);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StFetch;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_we    <= 1'b0;
      r_done      <= 1'b0;
      r_hold      <= 1'b1;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ram_addr  <= w_ram_addr_nxt;
      r_ram_wdata <= w_ram_wdata_nxt;
      r_ram_we    <= w_ram_we_nxt;
      r_done      <= w_done_nxt;
      r_hold      <= w_hold_nxt;
      r_err       <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_cnt_nxt       = r_cnt;
    w_ram_addr_nxt  = r_ram_addr;
    w_ram_wdata_nxt = r_ram_wdata;
    w_ram_we_nxt    = r_ram_we;
    w_done_nxt      = r_done;
    w_hold_nxt      = r_hold;
    w_err_nxt       = r_err;

    case (r_state)
      StFetch: begin
        if (r_cnt == SETTLE_LAST) begin
          w_cnt_nxt       = '0;
          w_ram_addr_nxt  = w_rom_addr;
          w_ram_wdata_nxt = i_bus_data;
          w_ram_we_nxt    = 1'b1;
          w_state_nxt     = StWrite;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      StWrite: begin
        if (i_ram_ack) begin
          w_ram_we_nxt = 1'b0;
          w_cnt_nxt    = '0;
          if (r_idx == IDX_LAST) begin
            w_done_nxt  = 1'b1;
            w_hold_nxt  = 1'b0;
            w_state_nxt = StDone;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = StFetch;
          end
        end else if (ACK_TIMEOUT != 0) begin
          if (r_cnt == TO_LAST) begin
            w_ram_we_nxt = 1'b0;
            w_err_nxt    = 1'b1;
            w_state_nxt  = StError;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      StDone: begin
        if (i_boot_req) begin
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b0;
          w_hold_nxt  = 1'b1;
          w_state_nxt = StFetch;
        end
      end
      StError: begin
        // Terminal until reset.
      end
      default: w_state_nxt = StFetch;
    endcase
  end

  assign o_rom_addr  = w_rom_addr;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_wdata = r_ram_wdata;
  assign o_ram_we    = r_ram_we;
  assign o_boot_done = r_done;
  assign o_cpu_hold  = r_hold;
  assign o_boot_err  = r_err;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed bench for boot_loader_ctrl: default build plus a BOOT_LEN=1, SETTLE_CYC=3 build.
module tb_boot_loader_ctrl;

  logic        clk = 1'b0;
  logic        rst, rst6;
  logic        boot_req, boot_req6;
  logic        ram_ack, ram_ack6;
  logic [15:0] rom_addr, ram_addr, rom_addr6, ram_addr6;
  logic [15:0] bus_data, ram_wdata, bus_data6, ram_wdata6;
  logic        ram_we, boot_done, cpu_hold, boot_err;
  logic        ram_we6, boot_done6, cpu_hold6, boot_err6;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // ROM contents {0x0000, 0x0005, 0xFFFD} at byte addresses 0, 2, 4.
  always_comb begin
    case (rom_addr)
      16'd0:   bus_data = 16'h0000;
      16'd2:   bus_data = 16'h0005;
      16'd4:   bus_data = 16'hFFFD;
      default: bus_data = 16'hDEAD;
    endcase
  end

  assign bus_data6 = (rom_addr6 == 16'd0) ? 16'hA5C3 : 16'hDEAD;

  boot_loader_ctrl u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_boot_req  (boot_req),
    .o_rom_addr  (rom_addr),
    .i_bus_data  (bus_data),
    .o_ram_addr  (ram_addr),
    .o_ram_wdata (ram_wdata),
    .o_ram_we    (ram_we),
    .i_ram_ack   (ram_ack),
    .o_boot_done (boot_done),
    .o_cpu_hold  (cpu_hold),
    .o_boot_err  (boot_err)
  );

  boot_loader_ctrl #(
    .BOOT_LEN   (1),
    .SETTLE_CYC (3)
  ) u_dut6 (
    .i_clk       (clk),
    .i_rst       (rst6),
    .i_boot_req  (boot_req6),
    .o_rom_addr  (rom_addr6),
    .i_bus_data  (bus_data6),
    .o_ram_addr  (ram_addr6),
    .o_ram_wdata (ram_wdata6),
    .o_ram_we    (ram_we6),
    .i_ram_ack   (ram_ack6),
    .o_boot_done (boot_done6),
    .o_cpu_hold  (cpu_hold6),
    .o_boot_err  (boot_err6)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset asserted mid-cycle, released just after an edge; the next edge is edge 1.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_write(input string tag, input logic [15:0] a, input logic [15:0] d);
    check_eq({tag, " we"}, 32'(ram_we), 32'd1);
    check_eq({tag, " addr"}, 32'(ram_addr), 32'(a));
    check_eq({tag, " data"}, 32'(ram_wdata), 32'(d));
  endtask

  task automatic check_status(input string tag, input logic d, input logic h, input logic e);
    check_eq({tag, " done"}, 32'(boot_done), 32'(d));
    check_eq({tag, " hold"}, 32'(cpu_hold), 32'(h));
    check_eq({tag, " err"}, 32'(boot_err), 32'(e));
  endtask

  initial begin
    rst       = 1'b1;
    rst6      = 1'b1;
    boot_req  = 1'b0;
    boot_req6 = 1'b0;
    ram_ack   = 1'b1;
    ram_ack6  = 1'b1;
    tick();

    // Reset values.
    check_eq("rst rom_addr", 32'(rom_addr), 32'd0);
    check_eq("rst ram_addr", 32'(ram_addr), 32'd0);
    check_eq("rst ram_wdata", 32'(ram_wdata), 32'd0);
    check_eq("rst ram_we", 32'(ram_we), 32'd0);
    check_status("rst", 1'b0, 1'b1, 1'b0);

    // 1: ack tied high, three words, done on edge 6.
    rst = 1'b0;
    tick();
    check_write("t1 e1", 16'd0, 16'h0000);
    tick();
    check_eq("t1 e2 we", 32'(ram_we), 32'd0);
    check_eq("t1 e2 rom_addr", 32'(rom_addr), 32'd2);
    tick();
    check_write("t1 e3", 16'd2, 16'h0005);
    tick();
    check_eq("t1 e4 we", 32'(ram_we), 32'd0);
    tick();
    check_write("t1 e5", 16'd4, 16'hFFFD);
    check_status("t1 e5", 1'b0, 1'b1, 1'b0);
    tick();
    check_status("t1 e6", 1'b1, 1'b0, 1'b0);
    check_eq("t1 e6 we", 32'(ram_we), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t1 idle we", 32'(ram_we), 32'd0);
      check_eq("t1 idle done", 32'(boot_done), 32'd1);
    end

    // 5: boot_req in DONE restarts the copy.
    boot_req = 1'b1;
    tick();
    boot_req = 1'b0;
    check_status("t5 req", 1'b0, 1'b1, 1'b0);
    check_eq("t5 req rom_addr", 32'(rom_addr), 32'd0);
    tick();
    check_write("t5 e1", 16'd0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t5 copy done", 32'(boot_done), 32'd0);
    end
    tick();
    check_status("t5 redone", 1'b1, 1'b0, 1'b0);

    // 2: ack withheld for three cycles on word 1; boot_req mid-copy ignored.
    do_reset();
    tick();
    tick();
    tick();
    check_write("t2 e3", 16'd2, 16'h0005);
    ram_ack  = 1'b0;
    boot_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_write("t2 stall", 16'd2, 16'h0005);
    end
    ram_ack  = 1'b1;
    boot_req = 1'b0;
    tick();
    check_eq("t2 e7 we", 32'(ram_we), 32'd0);
    tick();
    check_write("t2 e8", 16'd4, 16'hFFFD);
    check_eq("t2 e8 done", 32'(boot_done), 32'd0);
    tick();
    check_status("t2 e9", 1'b1, 1'b0, 1'b0);

    // 3: async reset during WRITE of word 2, then clean restart.
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    check_write("t3 e5", 16'd4, 16'hFFFD);
    rst = 1'b1;
    #1;
    check_eq("t3 async we", 32'(ram_we), 32'd0);
    check_eq("t3 async addr", 32'(ram_addr), 32'd0);
    check_eq("t3 async data", 32'(ram_wdata), 32'd0);
    check_eq("t3 async rom_addr", 32'(rom_addr), 32'd0);
    check_status("t3 async", 1'b0, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check_write("t3 restart e1", 16'd0, 16'h0000);
    for (int i = 0; i < 4; i++) tick();
    check_eq("t3 restart e5 done", 32'(boot_done), 32'd0);
    tick();
    check_status("t3 restart e6", 1'b1, 1'b0, 1'b0);

    // 4: ack never arrives; error after 15 WRITE cycles, sticky until reset.
    ram_ack = 1'b0;
    do_reset();
    tick();
    check_write("t4 e1", 16'd0, 16'h0000);
    for (int i = 0; i < 14; i++) tick();
    check_eq("t4 e15 err", 32'(boot_err), 32'd0);
    check_eq("t4 e15 we", 32'(ram_we), 32'd1);
    tick();
    check_status("t4 e16", 1'b0, 1'b1, 1'b1);
    check_eq("t4 e16 we", 32'(ram_we), 32'd0);
    boot_req = 1'b1;
    ram_ack  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_status("t4 stuck", 1'b0, 1'b1, 1'b1);
      check_eq("t4 stuck we", 32'(ram_we), 32'd0);
    end
    boot_req = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("t4 rst err", 32'(boot_err), 32'd0);
    tick();
    rst = 1'b0;

    // 6: BOOT_LEN=1, SETTLE_CYC=3.
    check_eq("t6 rst hold", 32'(cpu_hold6), 32'd1);
    rst6 = 1'b0;
    tick();
    check_eq("t6 e1 we", 32'(ram_we6), 32'd0);
    tick();
    check_eq("t6 e2 we", 32'(ram_we6), 32'd0);
    tick();
    check_eq("t6 e3 we", 32'(ram_we6), 32'd1);
    check_eq("t6 e3 addr", 32'(ram_addr6), 32'd0);
    check_eq("t6 e3 data", 32'(ram_wdata6), 32'h0000A5C3);
    check_eq("t6 e3 done", 32'(boot_done6), 32'd0);
    tick();
    check_eq("t6 e4 done", 32'(boot_done6), 32'd1);
    check_eq("t6 e4 hold", 32'(cpu_hold6), 32'd0);
    check_eq("t6 e4 we", 32'(ram_we6), 32'd0);
    check_eq("t6 e4 err", 32'(boot_err6), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
